// File: rtl/inst_fetch_queue_if.sv
//==============================================================================
// Module      : inst_fetch_queue_if
// Description : Fetch-side bundle between the fetch queue, the instruction
//               memory controller, the RoB redirect and the decoder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface inst_fetch_queue_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                  ic_req_valid;
  logic [31:0]           ic_req_addr;
  logic                  ic_resp_valid;
  logic [31:0]           ic_resp_inst;
  logic                  flush_in;
  logic [31:0]           flush_pc;
  logic                  dec_ready;
  logic                  dec_valid;
  logic [31:0]           dec_inst;
  logic [31:0]           dec_pc;
  logic [DEPTH_LOG2:0]   q_count;

  // Fetch queue side
  modport master (
    output ic_req_valid, ic_req_addr,
    input  ic_resp_valid, ic_resp_inst,
    input  flush_in, flush_pc,
    input  dec_ready,
    output dec_valid, dec_inst, dec_pc, q_count
  );

  // Environment side (memory controller, RoB, decoder)
  modport slave (
    input  ic_req_valid, ic_req_addr,
    output ic_resp_valid, ic_resp_inst,
    output flush_in, flush_pc,
    output dec_ready,
    input  dec_valid, dec_inst, dec_pc, q_count
  );
endinterface

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
//==============================================================================
// Module      : inst_fetch_queue
// Description : Sequential-PC fetch stage. Issues one outstanding 32-bit fetch
//               at a time, buffers {pc, inst} in a circular FIFO and presents
//               the head to the decoder. A RoB flush redirects the PC and drops
//               queued and in-flight instructions.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module inst_fetch_queue #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  wire logic          clk_in,
  input  wire logic          rst_in,
  input  wire logic          rdy_in,
  inst_fetch_queue_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t                state;
  logic                  req_q;
  logic [31:0]           pc;
  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic [DEPTH_LOG2:0]   count;

  logic [31:0]           inst_mem [1 << DEPTH_LOG2];
  logic [31:0]           pc_mem   [1 << DEPTH_LOG2];

  logic                  flush;
  logic                  push;
  logic                  pop;
  logic                  not_empty;
  logic [DEPTH_LOG2:0]   next_count;
  logic                  has_room;

  // Per-cycle queue bookkeeping: flush wins over push and pop
  always_comb begin
    not_empty  = (count != '0);
    flush      = rdy_in & bus.flush_in;
    pop        = rdy_in & ~bus.flush_in & not_empty & bus.dec_ready;
    push       = rdy_in & ~bus.flush_in & (state == WAIT) & bus.ic_resp_valid;
    next_count = count + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
    // count never exceeds the depth, so the MSB alone marks "full"
    has_room   = ~next_count[DEPTH_LOG2];
  end

  assign bus.ic_req_valid = req_q & rdy_in;
  assign bus.ic_req_addr  = pc;
  assign bus.dec_valid    = not_empty;
  assign bus.dec_inst     = not_empty ? inst_mem[head] : 32'h0;
  assign bus.dec_pc       = not_empty ? pc_mem[head]   : 32'h0;
  assign bus.q_count      = count;

  // Fetch FSM, PC and FIFO pointers; everything holds while rdy_in is low
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      req_q <= 1'b0;
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        pc    <= bus.flush_pc;
        req_q <= 1'b0;
        // An issued request whose response has not arrived must be swallowed
        case (state)
          IDLE:    state <= IDLE;
          REQ:     state <= DISCARD;
          WAIT:    state <= bus.ic_resp_valid ? IDLE : DISCARD;
          DISCARD: state <= bus.ic_resp_valid ? IDLE : DISCARD;
          default: state <= IDLE;
        endcase
      end else begin
        if (pop) begin
          head <= head + 1'b1;
        end
        if (push) begin
          tail <= tail + 1'b1;
          pc   <= pc + 32'd4;
        end
        count <= next_count;
        case (state)
          IDLE: begin
            if (has_room) begin
              state <= REQ;
              req_q <= 1'b1;
            end
          end
          REQ: begin
            state <= WAIT;
            req_q <= 1'b0;
          end
          WAIT: begin
            if (bus.ic_resp_valid) begin
              state <= has_room ? REQ : IDLE;
              req_q <= has_room;
            end
          end
          DISCARD: begin
            if (bus.ic_resp_valid) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // FIFO storage; entries are only meaningful between head and tail
  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem[tail] <= bus.ic_resp_inst;
      pc_mem[tail]   <= pc;
    end
  end

endmodule

`default_nettype wire
